// File: rtl/ahbl2avlmm_be_bridge_pkg.sv
// Shared definitions for the AHB-Lite to Avalon-MM byte-enable bridge.
// Holds the AHB transfer/response codes, the Avalon response codes, the bridge
// state encoding and two small decode helpers. No ports.
package ahbl2avlmm_be_bridge_pkg;

    localparam logic [1:0] AHB_HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] AHB_HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] AHB_HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] AHB_HTRANS_SEQ    = 2'b11;

    localparam logic AHB_HRESP_OKAY  = 1'b0;
    localparam logic AHB_HRESP_ERROR = 1'b1;

    localparam logic [1:0] AVL_RESPONSE_OKAY        = 2'b00;
    localparam logic [1:0] AVL_RESPONSE_RESERVED    = 2'b01;
    localparam logic [1:0] AVL_RESPONSE_SLVERR      = 2'b10;
    localparam logic [1:0] AVL_RESPONSE_DECODEERROR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_RDATA = 3'd3,
        ST_ERR1  = 3'd4,
        ST_ERR2  = 3'd5
    } bridge_state_e;

    // IDLE and BUSY carry no transfer.
    function automatic logic htrans_active(input logic [1:0] htrans);
        return (htrans == AHB_HTRANS_NONSEQ) || (htrans == AHB_HTRANS_SEQ);
    endfunction

    // SLVERR and DECODEERROR are turned into an AHB ERROR; the rest is data.
    function automatic logic avl_resp_ok(input logic [1:0] resp);
        return (resp == AVL_RESPONSE_OKAY) || (resp == AVL_RESPONSE_RESERVED);
    endfunction

endpackage

// File: rtl/ahbl2avlmm_be_decode.sv
// Combinational byte-lane decode for one AHB transfer.
//   addr_lo   in  LO_W      haddr bits below the bus-word boundary
//   hsize     in  3         AHB size (bytes = 1 << hsize)
//   be_o      out BE_WIDTH  active byte lanes (0 when illegal)
//   illegal_o out 1         transfer wider than the bus or not size-aligned
module ahbl2avlmm_be_decode
    import ahbl2avlmm_be_bridge_pkg::*;
#(
    parameter int BE_WIDTH = 4,
    parameter int LO_W     = 2
) (
    input  logic [LO_W-1:0]     addr_lo,
    input  logic [2:0]          hsize,
    output logic [BE_WIDTH-1:0] be_o,
    output logic                illegal_o
);

    logic [31:0] nbytes;
    logic [31:0] lo;

    assign nbytes    = 32'd1 << hsize;
    assign lo        = 32'(addr_lo);
    assign illegal_o = (nbytes > 32'(BE_WIDTH)) || ((lo & (nbytes - 32'd1)) != 32'd0);

    // Lane i is active when it falls in [lo, lo + nbytes).
    always_comb begin
        be_o = '0;
        for (int i = 0; i < BE_WIDTH; i++) begin
            be_o[i] = !illegal_o && (32'(i) >= lo) && (32'(i) < lo + nbytes);
        end
    end

endmodule

// File: rtl/ahbl2avlmm_be_bridge.sv
// Single-beat AHB-Lite slave to Avalon-MM master bridge with byte enables,
// two-cycle AHB ERROR response and a read-timeout watchdog.
//   clk, reset_n                      clock, async active-low reset
//   ahb_h{addr,write,size,trans,mastlock,wdata}  AHB-Lite slave inputs
//   ahb_hrdata, ahb_hready, ahb_hresp             AHB-Lite slave outputs
//   avl_{address,read,write,byteenable,burstcount,lock,writedata}  Avalon command
//   avl_{readdata,readdatavalid,waitrequest_n,response}            Avalon return
//
// state | meaning
// IDLE  | no data phase outstanding, ready for a new transfer
// WRITE | Avalon write issued, waiting for waitrequest_n
// READ  | Avalon read issued, waiting for waitrequest_n
// RDATA | read accepted, waiting for readdatavalid or timeout
// ERR1  | first ERROR cycle (hready low)
// ERR2  | second ERROR cycle (hready high, new transfer may be accepted)
module ahbl2avlmm_be_bridge
    import ahbl2avlmm_be_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH       = 32,
    parameter int DATA_WIDTH       = 32,
    parameter int BURSTCOUNT_WIDTH = 12,
    parameter int RD_TIMEOUT       = 256
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [ADDR_WIDTH-1:0]         ahb_haddr,
    input  logic                          ahb_hwrite,
    input  logic [2:0]                    ahb_hsize,
    input  logic [1:0]                    ahb_htrans,
    input  logic                          ahb_hmastlock,
    input  logic [DATA_WIDTH-1:0]         ahb_hwdata,
    output logic [DATA_WIDTH-1:0]         ahb_hrdata,
    output logic                          ahb_hready,
    output logic                          ahb_hresp,
    output logic [ADDR_WIDTH-1:0]         avl_address,
    output logic                          avl_read,
    output logic                          avl_write,
    output logic [DATA_WIDTH/8-1:0]       avl_byteenable,
    output logic [BURSTCOUNT_WIDTH-1:0]   avl_burstcount,
    output logic                          avl_lock,
    output logic [DATA_WIDTH-1:0]         avl_writedata,
    input  logic [DATA_WIDTH-1:0]         avl_readdata,
    input  logic                          avl_readdatavalid,
    input  logic                          avl_waitrequest_n,
    input  logic [1:0]                    avl_response
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int LO_W     = $clog2(BE_WIDTH);
    localparam int CNT_W    = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;

    bridge_state_e         state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [BE_WIDTH-1:0]   be_q, be_d, dec_be;
    logic                  lock_q, lock_d, dec_illegal;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  done, timeout_hit;

    ahbl2avlmm_be_decode #(
        .BE_WIDTH (BE_WIDTH),
        .LO_W     (LO_W)
    ) u_decode (
        .addr_lo   (ahb_haddr[LO_W-1:0]),
        .hsize     (ahb_hsize),
        .be_o      (dec_be),
        .illegal_o (dec_illegal)
    );

    // Fires in the RD_TIMEOUT-th RDATA cycle; counter is cleared on entry.
    assign timeout_hit = (RD_TIMEOUT != 0) && (cnt_q == CNT_W'(RD_TIMEOUT - 1));

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        be_d       = be_q;
        lock_d     = lock_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        ahb_hready = 1'b1;
        ahb_hresp  = AHB_HRESP_OKAY;
        ahb_hrdata = rdata_q;
        done       = 1'b0;

        case (state_q)
            ST_IDLE: done = 1'b1;
            ST_WRITE: begin
                ahb_hready = avl_waitrequest_n;
                done       = avl_waitrequest_n;
            end
            ST_READ: begin
                ahb_hready = 1'b0;
                if (avl_waitrequest_n) begin
                    state_d = ST_RDATA;
                    cnt_d   = '0;
                end
            end
            ST_RDATA: begin
                ahb_hready = 1'b0;
                cnt_d      = cnt_q + CNT_W'(1);
                // Data takes priority over a coincident timeout.
                if (avl_readdatavalid) begin
                    if (avl_resp_ok(avl_response)) begin
                        ahb_hready = 1'b1;
                        ahb_hrdata = avl_readdata;
                        rdata_d    = avl_readdata;
                        done       = 1'b1;
                    end else begin
                        state_d = ST_ERR1;
                    end
                end else if (timeout_hit) begin
                    state_d = ST_ERR1;
                end
            end
            ST_ERR1: begin
                ahb_hready = 1'b0;
                ahb_hresp  = AHB_HRESP_ERROR;
                state_d    = ST_ERR2;
            end
            ST_ERR2: begin
                ahb_hresp = AHB_HRESP_ERROR;
                done      = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        // Any cycle that completes a data phase can also take a new address.
        if (done) begin
            if (htrans_active(ahb_htrans)) begin
                addr_d = {ahb_haddr[ADDR_WIDTH-1:LO_W], {LO_W{1'b0}}};
                be_d   = dec_be;
                lock_d = ahb_hmastlock;
                if (dec_illegal) begin
                    state_d = ST_ERR1;
                end else if (ahb_hwrite) begin
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_READ;
                end
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            be_q    <= '0;
            lock_q  <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            lock_q  <= lock_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    assign avl_address    = addr_q;
    assign avl_byteenable = be_q;
    assign avl_lock       = lock_q;
    assign avl_write      = (state_q == ST_WRITE);
    assign avl_read       = (state_q == ST_READ);
    assign avl_burstcount = BURSTCOUNT_WIDTH'(1);
    assign avl_writedata  = ahb_hwdata;

endmodule

// File: tb/tb_ahbl2avlmm_be_bridge.sv
// Bench for ahbl2avlmm_be_bridge (64-bit data, read timeout of 4 cycles).
// Drives AHB transfers and plays the Avalon slave; expectations come from a
// transaction-level model of the bridge's documented timing.
module tb_ahbl2avlmm_be_bridge;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int BW = 8;
    localparam int CW = 12;
    localparam int TO = 4;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [AW-1:0]   ahb_haddr;
    logic            ahb_hwrite;
    logic [2:0]      ahb_hsize;
    logic [1:0]      ahb_htrans;
    logic            ahb_hmastlock;
    logic [DW-1:0]   ahb_hwdata;
    logic [DW-1:0]   ahb_hrdata;
    logic            ahb_hready;
    logic            ahb_hresp;
    logic [AW-1:0]   avl_address;
    logic            avl_read;
    logic            avl_write;
    logic [BW-1:0]   avl_byteenable;
    logic [CW-1:0]   avl_burstcount;
    logic            avl_lock;
    logic [DW-1:0]   avl_writedata;
    logic [DW-1:0]   avl_readdata;
    logic            avl_readdatavalid;
    logic            avl_waitrequest_n;
    logic [1:0]      avl_response;

    always #5 clk = ~clk;

    ahbl2avlmm_be_bridge #(
        .ADDR_WIDTH       (AW),
        .DATA_WIDTH       (DW),
        .BURSTCOUNT_WIDTH (CW),
        .RD_TIMEOUT       (TO)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .ahb_haddr         (ahb_haddr),
        .ahb_hwrite        (ahb_hwrite),
        .ahb_hsize         (ahb_hsize),
        .ahb_htrans        (ahb_htrans),
        .ahb_hmastlock     (ahb_hmastlock),
        .ahb_hwdata        (ahb_hwdata),
        .ahb_hrdata        (ahb_hrdata),
        .ahb_hready        (ahb_hready),
        .ahb_hresp         (ahb_hresp),
        .avl_address       (avl_address),
        .avl_read          (avl_read),
        .avl_write         (avl_write),
        .avl_byteenable    (avl_byteenable),
        .avl_burstcount    (avl_burstcount),
        .avl_lock          (avl_lock),
        .avl_writedata     (avl_writedata),
        .avl_readdata      (avl_readdata),
        .avl_readdatavalid (avl_readdatavalid),
        .avl_waitrequest_n (avl_waitrequest_n),
        .avl_response      (avl_response)
    );

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  size;
        bit          lock;
        logic [63:0] wdata;
        int          wt;    // cycles the Avalon command is held off
        int          lat;   // cycles from command acceptance to readdatavalid
        logic [1:0]  resp;
        logic [63:0] rdata;
        int          gap;   // idle bus cycles before the address is presented
    } xfer_t;

    xfer_t       q[$];
    xfer_t       cur, nxt, t;
    bit          cur_v, nxt_v, present, legal, rdv_sched, is_err;
    bit          exp_hready, exp_hresp, exp_w, exp_r;
    logic [63:0] exp_hrdata, last_rd;
    int          c, gap_left, cyc, endc, err_start;
    int          ntests = 0;
    int          nfail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        ntests++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit is_legal(input xfer_t x);
        int nb;
        nb = 1 << x.size;
        return (nb <= BW) && ((int'(x.addr[2:0]) % nb) == 0);
    endfunction

    function automatic logic [7:0] exp_be(input xfer_t x);
        logic [15:0] m;
        m = ((16'd1 << (16'd1 << x.size)) - 16'd1) << x.addr[2:0];
        return m[7:0];
    endfunction

    function automatic xfer_t mk(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                                 input int wt, input int lat, input logic [1:0] resp, input int gap);
        xfer_t x;
        x.wr    = wr;
        x.addr  = addr;
        x.size  = size;
        x.lock  = ($urandom_range(1, 0) != 0);
        x.wdata = {$urandom, $urandom};
        x.wt    = wt;
        x.lat   = lat;
        x.resp  = resp;
        x.rdata = {$urandom, $urandom};
        x.gap   = gap;
        return x;
    endfunction

    initial begin
        reset_n           = 1'b0;
        ahb_haddr         = '0;
        ahb_hwrite        = 1'b0;
        ahb_hsize         = 3'd0;
        ahb_htrans        = 2'b00;
        ahb_hmastlock     = 1'b0;
        ahb_hwdata        = '0;
        avl_readdata      = '0;
        avl_readdatavalid = 1'b0;
        avl_waitrequest_n = 1'b1;
        avl_response      = 2'b00;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_hready", 64'(ahb_hready), 64'd1);
        chk("rst_hresp", 64'(ahb_hresp), 64'd0);
        chk("rst_hrdata", ahb_hrdata, 64'd0);
        chk("rst_read", 64'(avl_read), 64'd0);
        chk("rst_write", 64'(avl_write), 64'd0);
        chk("rst_lock", 64'(avl_lock), 64'd0);
        chk("rst_be", 64'(avl_byteenable), 64'd0);
        chk("rst_addr", 64'(avl_address), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Directed cases first, then randomized traffic.
        t = mk(1'b1, 32'h1004, 3'd2, 0, 1, 2'd0, 0);
        t.wdata = 64'hDEADBEEF_00000000;
        q.push_back(t);
        q.push_back(mk(1'b0, 32'h2003, 3'd0, 2, 3, 2'd0, 0));   // byte read, wait + latency
        q.push_back(mk(1'b0, 32'h2002, 3'd2, 0, 1, 2'd0, 1));   // misaligned
        q.push_back(mk(1'b0, 32'h3000, 3'd3, 0, 2, 2'd2, 1));   // slave error
        q.push_back(mk(1'b0, 32'h3008, 3'd3, 1, 1, 2'd0, 0));   // accepted in ERR2
        q.push_back(mk(1'b0, 32'h4010, 3'd2, 0, 6, 2'd0, 1));   // timeout, late data
        q.push_back(mk(1'b1, 32'h0010, 3'd4, 0, 1, 2'd0, 0));   // too wide for the bus
        q.push_back(mk(1'b0, 32'h5006, 3'd1, 1, 4, 2'd1, 0));   // data wins over timeout
        q.push_back(mk(1'b1, 32'h6000, 3'd3, 3, 1, 2'd0, 0));
        q.push_back(mk(1'b1, 32'h6008, 3'd3, 0, 1, 2'd0, 0));   // back-to-back writes
        for (int i = 0; i < 60; i++) begin
            t = mk(($urandom_range(1, 0) != 0), $urandom,
                   ($urandom_range(7, 0) == 0) ? 3'($urandom_range(7, 4)) : 3'($urandom_range(3, 0)),
                   int'($urandom_range(3, 0)),
                   ($urandom_range(4, 0) == 0) ? int'($urandom_range(7, 5)) : int'($urandom_range(4, 1)),
                   ($urandom_range(5, 0) == 0) ? 2'($urandom_range(3, 2)) : 2'($urandom_range(1, 0)),
                   ($urandom_range(1, 0) != 0) ? 0 : int'($urandom_range(2, 1)));
            if ($urandom_range(3, 0) != 0) t.addr = t.addr & ~((32'd1 << t.size) - 32'd1);
            q.push_back(t);
        end

        cur_v    = 1'b0;
        nxt_v    = 1'b0;
        c        = 0;
        gap_left = 0;
        cyc      = 0;
        last_rd  = '0;
        while ((q.size() > 0 || nxt_v || cur_v) && cyc < 5000) begin
            if (!nxt_v && q.size() > 0) begin
                nxt      = q.pop_front();
                nxt_v    = 1'b1;
                gap_left = nxt.gap;
            end
            @(posedge clk);
            #1;
            cyc++;

            present = nxt_v && (gap_left == 0);
            if (present) begin
                ahb_htrans    = ($urandom_range(1, 0) != 0) ? 2'b10 : 2'b11;
                ahb_haddr     = nxt.addr;
                ahb_hwrite    = nxt.wr;
                ahb_hsize     = nxt.size;
                ahb_hmastlock = nxt.lock;
            end else begin
                ahb_htrans    = ($urandom_range(1, 0) != 0) ? 2'b00 : 2'b01;
                ahb_haddr     = $urandom;
                ahb_hwrite    = 1'($urandom_range(1, 0));
                ahb_hsize     = 3'($urandom_range(7, 0));
                ahb_hmastlock = 1'($urandom_range(1, 0));
            end

            legal     = cur_v && is_legal(cur);
            rdv_sched = legal && !cur.wr && (c == cur.wt + cur.lat);
            ahb_hwdata        = cur_v ? cur.wdata : {$urandom, $urandom};
            avl_waitrequest_n = cur_v ? (c >= cur.wt) : 1'($urandom_range(1, 0));
            avl_readdatavalid = rdv_sched ||
                                (!(legal && !cur.wr) && ($urandom_range(7, 0) == 0));
            avl_readdata      = rdv_sched ? cur.rdata : {$urandom, $urandom};
            avl_response      = rdv_sched ? cur.resp : 2'($urandom_range(3, 0));

            exp_hready = 1'b1;
            exp_hresp  = 1'b0;
            exp_w      = 1'b0;
            exp_r      = 1'b0;
            exp_hrdata = last_rd;
            is_err     = 1'b0;
            endc       = 0;
            err_start  = 0;
            if (cur_v) begin
                if (!legal) begin
                    is_err = 1'b1;
                end else if (cur.wr) begin
                    exp_w = 1'b1;
                    endc  = cur.wt;
                end else begin
                    exp_r = (c <= cur.wt);
                    if (cur.lat > TO) begin
                        is_err    = 1'b1;
                        err_start = cur.wt + 1 + TO;
                    end else if (cur.resp >= 2'd2) begin
                        is_err    = 1'b1;
                        err_start = cur.wt + cur.lat + 1;
                    end else begin
                        endc = cur.wt + cur.lat;
                        if (c == endc) exp_hrdata = cur.rdata;
                    end
                end
                if (is_err) begin
                    exp_hready = (c == err_start + 1);
                    exp_hresp  = (c >= err_start);
                end else begin
                    exp_hready = (c == endc);
                end
            end

            #4;
            chk("hready", 64'(ahb_hready), 64'(exp_hready));
            chk("hresp", 64'(ahb_hresp), 64'(exp_hresp));
            chk("hrdata", ahb_hrdata, exp_hrdata);
            chk("avl_write", 64'(avl_write), 64'(exp_w));
            chk("avl_read", 64'(avl_read), 64'(exp_r));
            chk("burstcount", 64'(avl_burstcount), 64'd1);
            if (exp_w || exp_r) begin
                chk("avl_address", 64'(avl_address), 64'({cur.addr[31:3], 3'b000}));
                chk("avl_byteenable", 64'(avl_byteenable), 64'(exp_be(cur)));
                chk("avl_lock", 64'(avl_lock), 64'(cur.lock));
                if (exp_w) chk("avl_writedata", avl_writedata, cur.wdata);
            end

            if (exp_hready) begin
                if (cur_v && legal && !cur.wr && !is_err) last_rd = cur.rdata;
                cur_v = 1'b0;
                if (present) begin
                    cur   = nxt;
                    cur_v = 1'b1;
                    nxt_v = 1'b0;
                    c     = 0;
                end else if (nxt_v && gap_left > 0) begin
                    gap_left--;
                end
            end else begin
                c++;
            end
        end
        chk("traffic_drained", 64'(q.size() + int'(nxt_v) + int'(cur_v)), 64'd0);

        // Reset while a read is stalled in its command phase.
        @(posedge clk);
        #1;
        ahb_htrans        = 2'b10;
        ahb_haddr         = 32'h0000_0040;
        ahb_hwrite        = 1'b0;
        ahb_hsize         = 3'd3;
        avl_waitrequest_n = 1'b0;
        avl_readdatavalid = 1'b0;
        @(posedge clk);
        #1;
        ahb_htrans = 2'b00;
        #2;
        chk("midrst_read_before", 64'(avl_read), 64'd1);
        chk("midrst_hready_before", 64'(ahb_hready), 64'd0);
        reset_n = 1'b0;
        #1;
        chk("midrst_read", 64'(avl_read), 64'd0);
        chk("midrst_write", 64'(avl_write), 64'd0);
        chk("midrst_hready", 64'(ahb_hready), 64'd1);
        chk("midrst_hresp", 64'(ahb_hresp), 64'd0);
        chk("midrst_hrdata", ahb_hrdata, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        avl_waitrequest_n = 1'b1;
        @(negedge clk);
        chk("postrst_read", 64'(avl_read), 64'd0);
        chk("postrst_hready", 64'(ahb_hready), 64'd1);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
